// File: rtl/afe_pkg.sv
// Shared definitions for the PPG analog-front-end emulator: state encodings,
// ADC constants and the default tissue model also used by controller benches.
package afe_pkg;

    typedef enum logic [1:0] {
        ST_DARK   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_TRACK  = 2'd2,
        ST_FAULT  = 2'd3
    } afe_state_t;

    localparam int         ADC_W   = 8;
    localparam logic [7:0] ADC_MID = 8'd128;
    localparam logic [7:0] ADC_MAX = 8'd255;
    localparam int         SIG_W   = 15;
    localparam int         GAIN_W  = 20;

    localparam int         DEF_HB_LOG2    = 9;
    localparam logic [7:0] DEF_DC_RED     = 8'd100;
    localparam logic [7:0] DEF_AC_RED     = 8'd20;
    localparam logic [7:0] DEF_DC_IR      = 8'd120;
    localparam logic [7:0] DEF_AC_IR      = 8'd30;
    localparam int         DEF_COMP_STEP  = 4;
    localparam int         DEF_SETTLE_CYC = 3;

    // Steady-state destination for an LED-select pattern.
    function automatic afe_state_t sel_state(input logic [1:0] sel);
        case (sel)
            2'b00:   return ST_DARK;
            2'b11:   return ST_FAULT;
            default: return ST_TRACK;
        endcase
    endfunction

endpackage

// File: rtl/afe_gain_clamp.sv
// PGA and ADC transfer: signed signal times (gain+1), offset to mid-scale,
// saturated into the 8-bit ADC range.
module afe_gain_clamp
    import afe_pkg::*;
(
    input  logic signed [SIG_W-1:0] sig,
    input  logic        [3:0]       gain,
    output logic        [ADC_W-1:0] code
);

    logic signed [5:0]        mult;
    logic signed [GAIN_W-1:0] g;
    logic signed [GAIN_W:0]   biased;

    always_comb begin
        mult   = $signed({2'b00, gain}) + 6'sd1;
        g      = GAIN_W'(sig) * GAIN_W'(mult);
        biased = (GAIN_W+1)'(g) + (GAIN_W+1)'($signed({1'b0, ADC_MID}));
        code   = biased[ADC_W-1:0];
        if (biased[GAIN_W]) begin
            code = '0;
        end else if (|biased[GAIN_W-1:ADC_W]) begin
            code = ADC_MAX;
        end
    end

endmodule

// File: rtl/ppg_afe_emulator.sv
// Behavioural stand-in for the pulse-oximeter AFE: synthesizes a triangular
// pulsatile photocurrent per LED and returns 8-bit ADC codes two cycles later.
module ppg_afe_emulator
    import afe_pkg::*;
#(
    parameter int         HB_LOG2    = DEF_HB_LOG2,
    parameter logic [7:0] DC_RED     = DEF_DC_RED,
    parameter logic [7:0] AC_RED     = DEF_AC_RED,
    parameter logic [7:0] DC_IR      = DEF_DC_IR,
    parameter logic [7:0] AC_IR      = DEF_AC_IR,
    parameter int         COMP_STEP  = DEF_COMP_STEP,
    parameter int         SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       LED_RED,
    input  logic       LED_IR,
    input  logic [3:0] LED_DRIVE,
    input  logic [6:0] DC_Comp,
    input  logic [3:0] PGA_Gain,
    output logic [7:0] ADC,
    output logic       ADC_valid,
    output logic       AFE_fault
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    logic [1:0]              sel;
    logic [1:0]              sel_reg;
    afe_state_t              state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [HB_LOG2-1:0]      ph_reg;

    logic [7:0]              tri_wave;
    logic [7:0]              dc_sel, ac_sel, ac_term;
    logic [8:0]              level;
    logic [12:0]             light;
    logic [SIG_W-1:0]        comp;
    logic signed [SIG_W-1:0] sig_next, sig_reg;
    logic [3:0]              gain_reg;
    logic                    s1_live_reg;

    logic [ADC_W-1:0]        code;
    logic [ADC_W-1:0]        adc_reg;
    logic                    valid_reg, fault_reg;

    assign sel = {LED_RED, LED_IR};

    // Any select change restarts the settle window; both LEDs on trumps everything.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (sel == 2'b11) begin
            state_next = ST_FAULT;
        end else if (sel != sel_reg) begin
            state_next = ST_SETTLE;
            cnt_next   = CNT_LOAD;
        end else if (state_reg == ST_SETTLE) begin
            if (cnt_reg == '0) begin
                state_next = sel_state(sel);
            end else begin
                cnt_next = cnt_reg - 1'b1;
            end
        end
    end

    always_comb begin
        tri_wave = ph_reg[HB_LOG2-1] ? ~ph_reg[HB_LOG2-2 -: 8] : ph_reg[HB_LOG2-2 -: 8];
        case (sel)
            2'b10: begin
                dc_sel = DC_RED;
                ac_sel = AC_RED;
            end
            2'b01: begin
                dc_sel = DC_IR;
                ac_sel = AC_IR;
            end
            default: begin
                dc_sel = '0;
                ac_sel = '0;
            end
        endcase
        ac_term  = 8'((16'(ac_sel) * 16'(tri_wave)) >> 8);
        level    = 9'(dc_sel) + 9'(ac_term);
        light    = 13'(LED_DRIVE) * 13'(level);
        comp     = SIG_W'(DC_Comp) * SIG_W'(COMP_STEP);
        sig_next = $signed(SIG_W'(light >> 2)) - $signed(comp);
    end

    afe_gain_clamp u_gain_clamp (
        .sig  (sig_reg),
        .gain (gain_reg),
        .code (code)
    );

    // state_reg doubles as the stage-1 tag: it is loaded on the same edge as sig_reg.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg     <= '0;
            state_reg   <= ST_DARK;
            cnt_reg     <= '0;
            ph_reg      <= '0;
            sig_reg     <= '0;
            gain_reg    <= '0;
            s1_live_reg <= 1'b0;
            adc_reg     <= '0;
            valid_reg   <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            sel_reg     <= sel;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ph_reg      <= ph_reg + 1'b1;
            sig_reg     <= sig_next;
            gain_reg    <= PGA_Gain;
            s1_live_reg <= 1'b1;

            valid_reg   <= 1'b0;
            fault_reg   <= 1'b0;
            if (s1_live_reg) begin
                case (state_reg)
                    ST_DARK, ST_TRACK: begin
                        adc_reg   <= code;
                        valid_reg <= 1'b1;
                    end
                    ST_FAULT: begin
                        adc_reg   <= ADC_MAX;
                        fault_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ADC       = adc_reg;
    assign ADC_valid = valid_reg;
    assign AFE_fault = fault_reg;

endmodule

// File: tb/tb_ppg_afe_emulator.sv
// Scoreboard bench for ppg_afe_emulator: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_ppg_afe_emulator;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       LED_RED, LED_IR;
    logic [3:0] LED_DRIVE;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic [7:0] ADC;
    logic       ADC_valid;
    logic       AFE_fault;

    always #5 CLK = ~CLK;

    ppg_afe_emulator #(.AC_RED(8'd0)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .LED_RED   (LED_RED),
        .LED_IR    (LED_IR),
        .LED_DRIVE (LED_DRIVE),
        .DC_Comp   (DC_Comp),
        .PGA_Gain  (PGA_Gain),
        .ADC       (ADC),
        .ADC_valid (ADC_valid),
        .AFE_fault (AFE_fault)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int          q_cyc[$];
    logic [9:0]  q_exp[$];
    string       q_name[$];
    logic [9:0]  mon_e;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input int d, input int adc, input int vld, input int flt,
                             input string nm);
        q_cyc.push_back(cyc + d);
        q_exp.push_back({adc[7:0], vld[0], flt[0]});
        q_name.push_back(nm);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            if (q_cyc[0] < cyc) begin
                chk({q_name[0], ".late"}, cyc, q_cyc[0]);
            end else begin
                mon_e = q_exp[0];
                chk({q_name[0], ".adc"},   int'(ADC),       int'(mon_e[9:2]));
                chk({q_name[0], ".valid"}, int'(ADC_valid), int'(mon_e[1]));
                chk({q_name[0], ".fault"}, int'(AFE_fault), int'(mon_e[0]));
                $display("txn %-18s cyc=%0d adc=%0d valid=%0d fault=%0d", q_name[0], cyc,
                         ADC, ADC_valid, AFE_fault);
            end
            void'(q_cyc.pop_front());
            void'(q_exp.pop_front());
            void'(q_name.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    int         c0;
    int         ws;
    int         p;
    logic [7:0] samp[1024];
    int         mn, mx, inval, permis;

    initial begin
        rst_n     = 1'b0;
        LED_RED   = 1'b0;
        LED_IR    = 1'b0;
        LED_DRIVE = 4'd0;
        DC_Comp   = 7'd10;
        PGA_Gain  = 4'd0;
        wait_cyc(3);
        chk("reset.adc",   int'(ADC),       0);
        chk("reset.valid", int'(ADC_valid), 0);
        chk("reset.fault", int'(AFE_fault), 0);

        // Dark: sig = -40 -> 88; gain 8 clamps low.
        rst_n = 1'b1;
        c0    = cyc;
        expect_at(1, 0, 0, 0, "post_rst_e1");
        expect_at(2, 88, 1, 0, "dark_pga0");
        wait_cyc(2);
        PGA_Gain = 4'd7;
        expect_at(1, 88, 1, 0, "dark_old");
        expect_at(2, 0, 1, 0, "dark_clamp_lo");
        wait_cyc(2);

        // Red, constant level 400/4 = 100.
        LED_RED = 1'b1; LED_DRIVE = 4'd4; DC_Comp = 7'd0; PGA_Gain = 4'd0;
        expect_at(1, 0, 1, 0, "red_pre");
        for (int i = 2; i <= 4; i++) expect_at(i, 0, 0, 0, "red_settle");
        expect_at(5, 228, 1, 0, "red_comp0");
        wait_cyc(5);
        DC_Comp = 7'd25;
        expect_at(2, 128, 1, 0, "red_comp25");
        wait_cyc(2);
        DC_Comp = 7'd20; PGA_Gain = 4'd3;
        expect_at(2, 208, 1, 0, "red_gain4");
        wait_cyc(2);
        PGA_Gain = 4'd15;
        expect_at(2, 255, 1, 0, "red_clamp_hi");
        wait_cyc(2);
        PGA_Gain = 4'd3;
        expect_at(2, 208, 1, 0, "red_gain4b");
        wait_cyc(2);

        // Both LEDs: fault, then exit through settle.
        LED_IR = 1'b1;
        expect_at(1, 208, 1, 0, "fault_pre");
        expect_at(2, 255, 0, 1, "fault");
        wait_cyc(3);
        LED_IR = 1'b0;
        expect_at(1, 255, 0, 1, "fault_hold");
        for (int i = 2; i <= 4; i++) expect_at(i, 255, 0, 0, "fault_exit_settle");
        expect_at(5, 208, 1, 0, "fault_exit_red");
        wait_cyc(5);

        // Red -> IR -> red with the second change one cycle into the settle window.
        LED_RED = 1'b0; LED_IR = 1'b1;
        expect_at(1, 208, 1, 0, "toggle_pre");
        for (int i = 2; i <= 5; i++) expect_at(i, 208, 0, 0, "toggle_settle");
        expect_at(6, 208, 1, 0, "toggle_red");
        wait_cyc(1);
        LED_RED = 1'b1; LED_IR = 1'b0;
        wait_cyc(5);

        // IR waveform over two heartbeats; output at cycle c reflects ph = c-c0-2.
        LED_RED = 1'b0; LED_IR = 1'b1; DC_Comp = 7'd30; PGA_Gain = 4'd0;
        ws = cyc + 5;
        for (int c = ws; c < ws + 1024; c++) begin
            p = (c - c0 - 2) % 512;
            if (p == 0)   expect_at(c - cyc, 128, 1, 0, "ir_ph0");
            if (p == 128) expect_at(c - cyc, 143, 1, 0, "ir_ph128");
            if (p == 256) expect_at(c - cyc, 157, 1, 0, "ir_ph256");
            if (p == 384) expect_at(c - cyc, 142, 1, 0, "ir_ph384");
        end
        wait_cyc(5);
        mn = 255; mx = 0; inval = 0;
        for (int i = 0; i < 1024; i++) begin
            samp[i] = ADC;
            if (!ADC_valid) inval++;
            if (int'(ADC) < mn) mn = int'(ADC);
            if (int'(ADC) > mx) mx = int'(ADC);
            @(negedge CLK);
        end
        permis = 0;
        for (int i = 0; i < 512; i++) if (samp[i] != samp[i+512]) permis++;
        chk("ir_min", mn, 128);
        chk("ir_max", mx, 157);
        chk("ir_invalid_cycles", inval, 0);
        chk("ir_period_mismatch", permis, 0);
        $display("txn ir_run            min=%0d max=%0d invalid=%0d period_diffs=%0d",
                 mn, mx, inval, permis);

        // Asynchronous reset between clock edges.
        @(posedge CLK);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.adc",   int'(ADC),       0);
        chk("async_rst.valid", int'(ADC_valid), 0);
        chk("async_rst.fault", int'(AFE_fault), 0);
        $display("txn async_reset       adc=%0d valid=%0d fault=%0d", ADC, ADC_valid, AFE_fault);
        LED_IR = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        expect_at(1, 0, 0, 0, "rerst_e1");
        expect_at(2, 8, 1, 0, "rerst_dark");
        wait_cyc(3);

        for (int i = 0; i < 20 && q_cyc.size() > 0; i++) @(negedge CLK);
        chk("scoreboard_drain", q_cyc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
